stream_upsizer: RTL and testbench

STREAM_UPSIZER -- requirements
Module: stream_upsizer

---
 rtl/stream_pkg.sv | 13 +
 rtl/stream_upsizer.sv | 90 +++++++++
 tb/tb_stream_upsizer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared stream defaults (beat width, packing ratio) and the lane-index width helper
// used by the stream FIFO blocks and the upsizer.
package stream_pkg;

  localparam int STREAM_IN_WIDTH = 8;
  localparam int STREAM_RATIO    = 4;

  // A single-lane stream still needs a 1-bit index to keep vectors legal.
  function automatic int lane_idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow input beats little-endian into one wide output word; in_last
// flushes a partial word early, with out_keep marking the lanes actually filled.
module stream_upsizer
  import stream_pkg::*;
#(
  parameter int IN_WIDTH  = STREAM_IN_WIDTH,
  parameter int RATIO     = STREAM_RATIO,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [RATIO-1:0]     out_keep,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CNT_WIDTH = lane_idx_width(RATIO);

  logic [CNT_WIDTH-1:0]             r_cnt;
  logic [RATIO-1:0][IN_WIDTH-1:0]   r_acc;
  logic [RATIO-1:0][IN_WIDTH-1:0]   r_out_data;
  logic [RATIO-1:0]                 r_out_keep;
  logic                             r_out_last;
  logic                             r_out_valid;

  logic                             w_in_fire;
  logic                             w_out_fire;
  logic                             w_complete;
  logic [RATIO-1:0]                 w_lane_sel;
  logic [RATIO-1:0]                 w_keep;
  logic [RATIO-1:0][IN_WIDTH-1:0]   w_word;

  assign in_ready   = ~r_out_valid | out_ready;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_complete = in_last | (r_cnt == CNT_WIDTH'(RATIO - 1));

  // Outgoing word: accumulated lanes below cnt, current beat in lane cnt, zero above.
  genvar gi;
  for (gi = 0; gi < RATIO; gi++) begin : g_lane
    assign w_lane_sel[gi] = (r_cnt == CNT_WIDTH'(gi));
    assign w_keep[gi]     = (CNT_WIDTH'(gi) <= r_cnt);
    assign w_word[gi]     = w_lane_sel[gi] ? in_data :
                            (w_keep[gi] ? r_acc[gi] : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_in_fire) begin
      if (w_complete) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt        <= r_cnt + CNT_WIDTH'(1);
        r_acc[r_cnt] <= in_data;
      end
    end
  end

  // A completing beat may load while the previous word drains, keeping full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_in_fire && w_complete) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_keep  <= w_keep;
      r_out_last  <= in_last;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: directed RATIO=4 sequence plus randomized RATIO=2 and
// RATIO=8 instances, all checked against scoreboard queues of expected words.
module tb_stream_upsizer;

  localparam int NB = 10000;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       d_rst_n;
  logic       rnd_rst_n;
  logic [7:0] d_in_data;
  logic       d_in_valid, d_in_last, d_in_ready;
  logic [31:0] d_out_data;
  logic [3:0] d_out_keep;
  logic       d_out_last, d_out_valid, d_out_ready;
  exp_t       d_q[$];

  stream_upsizer #(.IN_WIDTH(8), .RATIO(4)) u_dut (
    .clk      (clk),
    .rst_n    (d_rst_n),
    .in_data  (d_in_data),
    .in_valid (d_in_valid),
    .in_last  (d_in_last),
    .in_ready (d_in_ready),
    .out_data (d_out_data),
    .out_keep (d_out_keep),
    .out_last (d_out_last),
    .out_valid(d_out_valid),
    .out_ready(d_out_ready)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted; reports stall cycles.
  task automatic beat(input logic [7:0] data, input logic last, output int waits);
    logic rdy;
    rdy = 1'b0;
    waits = 0;
    d_in_valid = 1'b1;
    d_in_data  = data;
    d_in_last  = last;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      rdy = d_in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
    end
    check("beat_accepted", rdy, 1'b1);
    d_in_valid = 1'b0;
    d_in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 20 && d_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check(tag, d_q.size(), 0);
  endtask

  // Directed-instance output monitor.
  initial begin : d_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (d_out_valid && d_out_ready) begin
        if (d_q.size() == 0) begin
          check("d_unexpected_word", d_out_valid, 1'b0);
        end else begin
          e = d_q.pop_front();
          check("d_word", {64'(d_out_data), 8'(d_out_keep), d_out_last}, e);
        end
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_rnd
    localparam int R = (gi == 0) ? 2 : 8;

    logic [7:0]     in_data;
    logic           in_valid, in_last, in_ready;
    logic [8*R-1:0] out_data;
    logic [R-1:0]   out_keep;
    logic           out_last, out_valid, out_ready;
    logic           done;
    int             beats = 0;
    exp_t           q[$];

    stream_upsizer #(.IN_WIDTH(8), .RATIO(R)) u_dut (
      .clk      (clk),
      .rst_n    (rnd_rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_keep (out_keep),
      .out_last (out_last),
      .out_valid(out_valid),
      .out_ready(out_ready)
    );

    initial begin : drive
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      out_ready = 1'b0;
      done     = 1'b0;
      wait (rnd_rst_n === 1'b1);
      while (beats < NB) begin
        @(posedge clk);
        #1;
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = 8'($urandom_range(0, 255));
        in_last   = ($urandom_range(0, 7) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 200 && (q.size() != 0 || out_valid); c++) begin
        @(posedge clk);
        #1;
      end
      done = 1'b1;
    end

    // Scoreboard model: packs accepted beats independently of the DUT.
    initial begin : mon
      logic [63:0] m_word;
      logic [7:0]  m_keep;
      int          m_cnt;
      logic        hold_prev;
      logic [72:0] prev_out;
      exp_t        e;
      m_word = '0;
      m_keep = '0;
      m_cnt = 0;
      hold_prev = 1'b0;
      prev_out = '0;
      forever begin
        @(negedge clk);
        if (rnd_rst_n) begin
          check($sformatf("r%0d_in_ready", R), in_ready, !out_valid || out_ready);
          if (hold_prev)
            check($sformatf("r%0d_hold", R),
                  {out_valid, 64'(out_data), 8'(out_keep), out_last}, {1'b1, prev_out});
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              check($sformatf("r%0d_unexpected_word", R), out_valid, 1'b0);
            end else begin
              e = q.pop_front();
              check($sformatf("r%0d_word", R), {64'(out_data), 8'(out_keep), out_last}, e);
            end
          end
          if (in_valid && in_ready) begin
            m_word[m_cnt*8 +: 8] = in_data;
            m_keep[m_cnt] = 1'b1;
            m_cnt++;
            beats++;
            if (m_cnt == R || in_last) begin
              q.push_back({m_word, m_keep, in_last});
              m_word = '0;
              m_keep = '0;
              m_cnt = 0;
            end
          end
          hold_prev = out_valid && !out_ready;
          prev_out  = {64'(out_data), 8'(out_keep), out_last};
        end
      end
    end
  end

  initial begin : main
    int w;
    d_rst_n = 1'b0;
    rnd_rst_n = 1'b0;
    d_in_valid = 1'b0;
    d_in_data = '0;
    d_in_last = 1'b0;
    d_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {d_out_valid, d_out_last, d_out_keep, d_out_data}, '0);
    check("rst_in_ready", d_in_ready, 1'b1);
    d_rst_n = 1'b1;
    rnd_rst_n = 1'b1;

    // Full words at rate.
    d_q.push_back({64'h44332211, 8'hf, 1'b0});
    d_q.push_back({64'h88776655, 8'hf, 1'b0});
    for (int i = 1; i <= 8; i++) begin
      beat(8'(17 * i), 1'b0, w);
      check($sformatf("rate_bubble_%0d", i), w, 0);
      check("rate_in_ready", d_in_ready, 1'b1);
    end
    drain("rate_drain");

    // Short flush, one cycle after the last beat.
    d_q.push_back({64'h0000A2A1, 8'h3, 1'b1});
    beat(8'hA1, 1'b0, w);
    beat(8'hA2, 1'b1, w);
    check("flush_latency", {d_out_valid, d_out_data, d_out_keep, d_out_last},
          {1'b1, 32'h0000A2A1, 4'b0011, 1'b1});
    drain("flush_drain");

    // Backpressure: held word stable, stalled beat not lost.
    d_q.push_back({64'h14131211, 8'hf, 1'b0});
    d_q.push_back({64'h18171615, 8'hf, 1'b0});
    d_out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) beat(8'h10 + 8'(i), 1'b0, w);
    d_in_valid = 1'b1;
    d_in_data = 8'h15;
    d_in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", d_in_ready, 1'b0);
      check("bp_hold", {d_out_valid, d_out_data, d_out_keep, d_out_last},
            {1'b1, 32'h14131211, 4'hf, 1'b0});
    end
    @(posedge clk);
    #1;
    d_out_ready = 1'b1;
    for (int i = 5; i <= 8; i++) beat(8'h10 + 8'(i), 1'b0, w);
    drain("bp_drain");

    // Boundaries: last on beat 4, last on beat 1.
    d_q.push_back({64'h34333231, 8'hf, 1'b1});
    for (int i = 1; i <= 4; i++) beat(8'h30 + 8'(i), (i == 4), w);
    d_q.push_back({64'h00000041, 8'h1, 1'b1});
    beat(8'h41, 1'b1, w);
    drain("boundary_drain");

    // Reset with a pending output word.
    d_out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) beat(8'h60 + 8'(i), 1'b0, w);
    d_rst_n = 1'b0;
    #1;
    check("rst_pending_outputs", {d_out_valid, d_out_last, d_out_keep, d_out_data}, '0);
    check("rst_pending_in_ready", d_in_ready, 1'b1);
    @(posedge clk);
    #1;
    d_out_ready = 1'b1;
    d_rst_n = 1'b1;

    // Reset after two beats of a partial word.
    beat(8'h51, 1'b0, w);
    beat(8'h52, 1'b0, w);
    d_rst_n = 1'b0;
    #1;
    check("rst_partial_outputs", {d_out_valid, d_out_last, d_out_keep, d_out_data}, '0);
    repeat (2) @(posedge clk);
    #1;
    d_rst_n = 1'b1;
    d_q.push_back({64'h04030201, 8'hf, 1'b0});
    for (int i = 1; i <= 4; i++) begin
      beat(8'(i), 1'b0, w);
      if (i == 1) check("rst_first_beat_wait", w, 0);
    end
    drain("rst_drain");
    repeat (10) @(posedge clk);

    for (int c = 0; c < 80000 && !(g_rnd[0].done && g_rnd[1].done); c++) @(posedge clk);
    #1;
    check("r2_done", g_rnd[0].done, 1'b1);
    check("r8_done", g_rnd[1].done, 1'b1);
    check("r2_queue_empty", g_rnd[0].q.size(), 0);
    check("r8_queue_empty", g_rnd[1].q.size(), 0);
    check("d_queue_empty", d_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
